// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited in-order imem requests, prefetch FIFO of {pc, instr}.
// Response to if_valid is one cycle; issue stalls while outstanding+buffered entries fill FIFO_DEPTH.
module mips_fetch_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     pop_i,
   output logic [W-1:0]             rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;

   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

module mips_fetch_unit #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_pc_plus4,
   input  logic              id_ready
);
   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [CW-1:0]        drop_q, drop_d;
   logic [CW-1:0]        outstanding, count;
   logic [CW:0]          credits_used;
   logic                 grant, resp_keep, pop;
   logic [ADDR_W-1:0]    rq_pc;
   logic [ADDR_W+31:0]   head;

   // Credits count from registered occupancy only, so a same-cycle pop never frees a slot early.
   assign credits_used = {1'b0, outstanding} + {1'b0, count};
   assign imem_req     = !rst && !redirect && (credits_used < DEPTH_C);
   assign imem_addr    = pc_q;
   assign grant        = imem_req && imem_gnt;
   assign resp_keep    = imem_rvalid && !redirect && (drop_q == '0);
   assign if_valid     = !rst && (count != '0);
   assign pop          = if_valid && id_ready && !redirect;
   assign {if_pc, if_instr} = head;
   assign if_pc_plus4  = if_pc + ADDR_W'(4);

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect) begin
         pc_d   = redirect_pc;
         drop_d = outstanding - CW'(imem_rvalid);
      end else begin
         if (grant) pc_d = pc_q + ADDR_W'(4);
         if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   // The request-PC queue holds exactly the granted-but-unreturned requests, so its occupancy is the outstanding count.
   mips_fetch_fifo #(.W(ADDR_W), .DEPTH(FIFO_DEPTH)) u_req_q (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (1'b0),
      .push_i  (grant),
      .wdata_i (pc_q),
      .pop_i   (imem_rvalid),
      .rdata_o (rq_pc),
      .count_o (outstanding)
   );

   mips_fetch_fifo #(.W(ADDR_W + 32), .DEPTH(FIFO_DEPTH)) u_pf_q (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (redirect),
      .push_i  (resp_keep),
      .wdata_i ({rq_pc, imem_rdata}),
      .pop_i   (pop),
      .rdata_o (head),
      .count_o (count)
   );
endmodule
